// File: rtl/mux_arbiter_pkg.sv
// mux_arb_pkg: flit type codes, FSM state encoding and mux select codes shared by the arbiter slice
package mux_arb_pkg;
  localparam int DATAW = 66;
  localparam int TYPEW = 2;
  localparam int TIMEOUT = 64;
  typedef logic [TYPEW-1:0] flit_type_t;
  localparam flit_type_t TYPE_NONE = 2'd0;
  localparam flit_type_t TYPE_HEAD = 2'd1;
  localparam flit_type_t TYPE_DATA = 2'd2;
  localparam flit_type_t TYPE_TAIL = 2'd3;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOCK0 = 2'd1;
  localparam logic [1:0] LOCK1 = 2'd2;
  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_P0 = 2'b01;
  localparam logic [1:0] SEL_P1 = 2'b10;
endpackage

// File: rtl/mux_arbiter_if.sv
// mux_arbiter_if: input-port flit status, downstream ready and arbiter select/grant/error outputs
interface mux_arbiter_if;
  import mux_arb_pkg::*;
  logic ivalid_0;
  flit_type_t itype_0;
  logic ivalid_1;
  flit_type_t itype_1;
  logic ordy;
  logic [1:0] sel;
  logic grant_0;
  logic grant_1;
  logic err;
  modport master (
    output ivalid_0, itype_0, ivalid_1, itype_1, ordy,
    input sel, grant_0, grant_1, err
  );
  modport slave (
    input ivalid_0, itype_0, ivalid_1, itype_1, ordy,
    output sel, grant_0, grant_1, err
  );
endinterface

// File: rtl/mux_arbiter_rr_pick2.sv
// rr_pick2: combinational 2-request round-robin picker; ptr selects the preferred request on contention
module rr_pick2 (
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  output logic [1:0] gnt_o
);
  assign gnt_o[0] = req_i[0] && (!req_i[1] || !ptr_i);
  assign gnt_o[1] = req_i[1] && (!req_i[0] || ptr_i);
endmodule

// File: rtl/mux_arbiter.sv
// mux_arbiter: packet-level 2:1 round-robin arbiter; define MUX_ARB_TIMEOUT_EN to force release of an idle lock
module mux_arbiter
  import mux_arb_pkg::*;
(
  input logic clk,
  input logic rst,
  mux_arbiter_if.slave bus
);
  logic [1:0] state_q, state_d, req, pick;
  logic rr_ptr_q, rr_ptr_d, err_q, err_d, hd_q, hd_d;
  logic lk0, lk1, g0, g1, gv, tail, to;
  flit_type_t gt;
  assign req = {bus.ivalid_1 && bus.itype_1 == TYPE_HEAD, bus.ivalid_0 && bus.itype_0 == TYPE_HEAD};
  rr_pick2 u_pick (.req_i(req), .ptr_i(rr_ptr_q), .gnt_o(pick));
  assign lk0 = state_q == LOCK0;
  assign lk1 = state_q == LOCK1;
  assign g0 = lk0 && bus.ivalid_0 && bus.ordy;
  assign g1 = lk1 && bus.ivalid_1 && bus.ordy;
  assign gv = g0 || g1;
  assign gt = lk1 ? bus.itype_1 : bus.itype_0;
  assign tail = gv && gt == TYPE_TAIL;
`ifdef MUX_ARB_TIMEOUT_EN
  logic [7:0] cnt_q;
  logic stall;
  assign stall = (lk0 && !bus.ivalid_0) || (lk1 && !bus.ivalid_1);
  assign to = stall && cnt_q == 8'(TIMEOUT - 1);
  always_ff @(posedge clk)
    if (rst) cnt_q <= '0;
    else cnt_q <= (gv || state_d != state_q) ? '0 : stall ? cnt_q + 8'd1 : cnt_q;
`else
  assign to = 1'b0;
`endif
  // hd_q marks that the locked packet's HEAD was consumed, so a later HEAD is a protocol error
  always_comb begin
    state_d = state_q;
    rr_ptr_d = rr_ptr_q;
    hd_d = hd_q || gv;
    err_d = 1'b0;
    if (state_q == IDLE) begin
      state_d = pick[0] ? LOCK0 : pick[1] ? LOCK1 : IDLE;
      hd_d = 1'b0;
      err_d = (bus.ivalid_0 && bus.itype_0 != TYPE_HEAD) || (bus.ivalid_1 && bus.itype_1 != TYPE_HEAD);
    end else if (lk0 || lk1) begin
      err_d = (gv && ((gt == TYPE_HEAD && hd_q) || gt == TYPE_NONE)) || to;
      state_d = (tail || to) ? IDLE : state_q;
      rr_ptr_d = (tail || to) ? lk0 : rr_ptr_q;
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      rr_ptr_q <= 1'b0;
      err_q <= 1'b0;
      hd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_ptr_q <= rr_ptr_d;
      err_q <= err_d;
      hd_q <= hd_d;
    end
  assign bus.sel = lk0 ? SEL_P0 : lk1 ? SEL_P1 : SEL_NONE;
  assign bus.grant_0 = g0;
  assign bus.grant_1 = g1;
  assign bus.err = err_q;
endmodule

// File: tb/tb_mux_arbiter.sv
// tb_mux_arbiter: table-driven vectors plus reset/timeout sequences, checked through an expected-value queue
module tb_mux_arbiter;
  import mux_arb_pkg::*;
  typedef struct packed {
    logic rst;
    logic v0;
    logic [1:0] t0;
    logic v1;
    logic [1:0] t1;
    logic ordy;
    logic [4:0] exp;
  } vec_t;
  localparam logic [1:0] N = TYPE_NONE, H = TYPE_HEAD, D = TYPE_DATA, T = TYPE_TAIL;
  logic clk = 1'b0;
  logic rst;
  vec_t tbl[$];
  logic [4:0] sb[$];
  int pass_n = 0;
  int total_n = 0;
  always #5 clk = ~clk;
  mux_arbiter_if bus();
  mux_arbiter dut (.clk(clk), .rst(rst), .bus(bus));
  function automatic vec_t mk(logic r, logic v0, logic [1:0] t0, logic v1, logic [1:0] t1, logic o,
                              logic [1:0] s, logic g0, logic g1, logic e);
    return {r, v0, t0, v1, t1, o, s, g0, g1, e};
  endfunction
  task automatic step(input vec_t v, input string nm);
    logic [4:0] got, want;
    rst = v.rst;
    bus.ivalid_0 = v.v0;
    bus.itype_0 = v.t0;
    bus.ivalid_1 = v.v1;
    bus.itype_1 = v.t1;
    bus.ordy = v.ordy;
    sb.push_back(v.exp);
    @(negedge clk);
    got = {bus.sel, bus.grant_0, bus.grant_1, bus.err};
    total_n++;
    if (sb.size() == 0) $display("FAIL %s: expected queue empty, got sel/g0/g1/err=%b", nm, got);
    else begin
      want = sb.pop_front();
      if (got === want) pass_n++;
      else $display("FAIL %s: sel/g0/g1/err got %b want %b", nm, got, want);
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    rst = 1'b1;
    bus.ivalid_0 = 1'b0;
    bus.itype_0 = N;
    bus.ivalid_1 = 1'b0;
    bus.itype_1 = N;
    bus.ordy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tbl.push_back(mk(0, 0, N, 0, N, 1, 2'b00, 0, 0, 0));
    // contention: port0 first after reset, then port1
    tbl.push_back(mk(0, 1, H, 1, H, 1, 2'b00, 0, 0, 0));
    tbl.push_back(mk(0, 1, H, 1, H, 1, 2'b01, 1, 0, 0));
    tbl.push_back(mk(0, 1, T, 1, H, 1, 2'b01, 1, 0, 0));
    tbl.push_back(mk(0, 1, H, 1, H, 1, 2'b00, 0, 0, 0));
    tbl.push_back(mk(0, 1, H, 1, H, 1, 2'b10, 0, 1, 0));
    tbl.push_back(mk(0, 1, H, 1, T, 1, 2'b10, 0, 1, 0));
    tbl.push_back(mk(0, 1, H, 0, N, 1, 2'b00, 0, 0, 0));
    tbl.push_back(mk(0, 1, H, 0, N, 1, 2'b01, 1, 0, 0));
    tbl.push_back(mk(0, 1, T, 0, N, 1, 2'b01, 1, 0, 0));
    tbl.push_back(mk(0, 0, N, 0, N, 1, 2'b00, 0, 0, 0));
    // 5-flit packet with ordy low 4 cycles and an input bubble
    tbl.push_back(mk(0, 1, H, 0, N, 1, 2'b00, 0, 0, 0));
    tbl.push_back(mk(0, 1, H, 0, N, 1, 2'b01, 1, 0, 0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 1, D, 0, N, 0, 2'b01, 0, 0, 0));
    tbl.push_back(mk(0, 1, D, 0, N, 1, 2'b01, 1, 0, 0));
    tbl.push_back(mk(0, 0, N, 0, N, 1, 2'b01, 0, 0, 0));
    tbl.push_back(mk(0, 1, D, 0, N, 1, 2'b01, 1, 0, 0));
    tbl.push_back(mk(0, 1, D, 0, N, 1, 2'b01, 1, 0, 0));
    tbl.push_back(mk(0, 1, T, 0, N, 1, 2'b01, 1, 0, 0));
    tbl.push_back(mk(0, 0, N, 0, N, 1, 2'b00, 0, 0, 0));
    for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("tbl[%0d]", i));
    // reset in LOCK1 aborts the lock and restores port0 preference
    step(mk(0, 0, N, 1, H, 1, 2'b00, 0, 0, 0), "rst_pre_idle");
    step(mk(0, 0, N, 1, H, 1, 2'b10, 0, 1, 0), "rst_pre_lock1");
    step(mk(1, 0, N, 0, N, 1, 2'b10, 0, 0, 0), "rst_asserted");
    step(mk(0, 0, N, 0, N, 1, 2'b00, 0, 0, 0), "rst_idle");
    step(mk(0, 1, H, 1, H, 1, 2'b00, 0, 0, 0), "rst_both_idle");
    step(mk(0, 1, H, 1, H, 1, 2'b01, 1, 0, 0), "rst_port0_wins");
    step(mk(0, 1, T, 1, H, 1, 2'b01, 1, 0, 0), "rst_port0_tail");
    step(mk(0, 0, N, 1, H, 1, 2'b00, 0, 0, 0), "rst_p1_idle");
    step(mk(0, 0, N, 1, H, 1, 2'b10, 0, 1, 0), "rst_p1_head");
    step(mk(0, 0, N, 1, T, 1, 2'b10, 0, 1, 0), "rst_p1_tail");
    step(mk(0, 0, N, 0, N, 1, 2'b00, 0, 0, 0), "rst_done");
    // protocol errors: DATA at idle head, repeated HEAD, NONE granted
    step(mk(0, 0, N, 1, D, 1, 2'b00, 0, 0, 0), "err_data_idle");
    step(mk(0, 0, N, 0, N, 1, 2'b00, 0, 0, 1), "err_data_pulse");
    step(mk(0, 0, N, 0, N, 1, 2'b00, 0, 0, 0), "err_data_clear");
    step(mk(0, 0, N, 1, H, 1, 2'b00, 0, 0, 0), "err_p1_idle");
    step(mk(0, 0, N, 1, H, 1, 2'b10, 0, 1, 0), "err_p1_head");
    step(mk(0, 0, N, 1, H, 1, 2'b10, 0, 1, 0), "err_dup_head");
    step(mk(0, 0, N, 1, N, 1, 2'b10, 0, 1, 1), "err_dup_pulse");
    step(mk(0, 0, N, 1, T, 1, 2'b10, 0, 1, 1), "err_none_pulse");
    step(mk(0, 0, N, 0, N, 1, 2'b00, 0, 0, 0), "err_done");
    // port0 locked with no input for 64 cycles while port1 waits with a HEAD
    step(mk(0, 1, H, 0, N, 1, 2'b00, 0, 0, 0), "to_idle");
    step(mk(0, 1, H, 0, N, 1, 2'b01, 1, 0, 0), "to_head");
    for (int i = 0; i < 64; i++) step(mk(0, 0, N, 1, H, 1, 2'b01, 0, 0, 0), $sformatf("to_wait[%0d]", i));
`ifdef MUX_ARB_TIMEOUT_EN
    step(mk(0, 0, N, 1, H, 1, 2'b00, 0, 0, 1), "to_release");
`else
    step(mk(0, 0, N, 1, H, 1, 2'b01, 0, 0, 0), "to_still_locked");
    step(mk(0, 1, T, 1, H, 1, 2'b01, 1, 0, 0), "to_p0_tail");
    step(mk(0, 0, N, 1, H, 1, 2'b00, 0, 0, 0), "to_p1_idle");
`endif
    step(mk(0, 0, N, 1, H, 1, 2'b10, 0, 1, 0), "to_p1_head");
    step(mk(0, 0, N, 1, T, 1, 2'b10, 0, 1, 0), "to_p1_tail");
    step(mk(0, 0, N, 0, N, 1, 2'b00, 0, 0, 0), "to_done");
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
